muldiv_unit: RTL and testbench

Iterative, parametrised RV32M multiply/divide unit for the execute stage, successor to the single-cycle MUL/DIV paths of the combinational ALU. It accepts one operation per START handshake and runs a WIDTH-cycle radix-2 shift-add (multiply) or restoring (divide) loop. It then applies sign correction and presents the result with a one-cycle DONE pulse. The pipeline stalls on BUSY and captures RESULT on DONE; KILL aborts an operation on a flush.

---
 rtl/muldiv_unit.sv | 171 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Unsigned magnitudes are processed for WIDTH cycles, then sign correction is applied.
// Divide-by-zero and signed overflow bypass the loop and finish in one cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic [2:0]       mdop_i,
  input  logic [WIDTH-1:0] operand1_i,
  input  logic [WIDTH-1:0] operand2_i,
  input  logic             kill_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CntW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MinInt = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e              state_q;
  logic [2:0]          mdop_q;
  logic [CntW-1:0]     cnt_q;
  logic [2*WIDTH-1:0]  acc_q;
  logic [WIDTH-1:0]    opnd_q;
  logic                negQ_q;
  logic                negR_q;
  logic                busy_q;
  logic                done_q;
  logic [WIDTH-1:0]    result_q;

  logic                isDiv;
  logic                op1Signed;
  logic                op2Signed;
  logic                neg1;
  logic                neg2;
  logic [WIDTH-1:0]    abs1;
  logic [WIDTH-1:0]    abs2;
  logic                divByZero;
  logic                divOverflow;
  logic [WIDTH-1:0]    fastResult;
  logic [WIDTH:0]      mulSum;
  logic [2*WIDTH-1:0]  accMul_d;
  logic [WIDTH:0]      divTop;
  logic [WIDTH:0]      divDiff;
  logic [2*WIDTH-1:0]  accDiv_d;
  logic [2*WIDTH-1:0]  prodFix;
  logic [WIDTH-1:0]    quoFix;
  logic [WIDTH-1:0]    remFix;
  logic [WIDTH-1:0]    result_d;

  // Decode the incoming request: operand signedness, magnitudes and the one-cycle special cases.
  always_comb begin
    isDiv       = mdop_i[2];
    op1Signed   = isDiv ? ~mdop_i[0] : (mdop_i[1:0] == 2'b01 || mdop_i[1:0] == 2'b10);
    op2Signed   = isDiv ? ~mdop_i[0] : (mdop_i[1:0] == 2'b01);
    neg1        = op1Signed & operand1_i[WIDTH-1];
    neg2        = op2Signed & operand2_i[WIDTH-1];
    abs1        = neg1 ? -operand1_i : operand1_i;
    abs2        = neg2 ? -operand2_i : operand2_i;
    divByZero   = isDiv && (operand2_i == '0);
    divOverflow = isDiv && !mdop_i[0] && (operand1_i == MinInt) && (operand2_i == '1);
    fastResult  = '0;
    if (divByZero) begin
      fastResult = mdop_i[1] ? operand1_i : '1;
    end else if (divOverflow) begin
      fastResult = mdop_i[1] ? '0 : operand1_i;
    end
  end

  // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    accMul_d = {mulSum, acc_q[WIDTH-1:1]};
    divTop   = acc_q[2*WIDTH-1:WIDTH-1];
    divDiff  = divTop - {1'b0, opnd_q};
    accDiv_d = divDiff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                              : {divDiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  // Sign correction and output selection applied once the loop has finished.
  always_comb begin
    prodFix  = negQ_q ? -acc_q : acc_q;
    quoFix   = negQ_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    remFix   = negR_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    result_d = remFix;
    case (mdop_q)
      3'b000:                 result_d = prodFix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: result_d = prodFix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         result_d = quoFix;
      default:                result_d = remFix;
    endcase
  end

  // Control FSM with the datapath registers and registered BUSY/DONE/RESULT.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      mdop_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      negQ_q   <= 1'b0;
      negR_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          if (start_i) begin
            mdop_q <= mdop_i;
            cnt_q  <= '0;
            negQ_q <= neg1 ^ neg2;
            negR_q <= neg1;
            if (divByZero || divOverflow) begin
              result_q <= fastResult;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              acc_q   <= isDiv ? {{WIDTH{1'b0}}, abs1} : {{WIDTH{1'b0}}, abs2};
              opnd_q  <= isDiv ? abs2 : abs1;
              busy_q  <= 1'b1;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          done_q <= 1'b0;
          if (kill_i) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            acc_q <= mdop_q[2] ? accDiv_d : accMul_d;
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == CntW'(WIDTH - 1)) begin
              state_q <= FIX;
            end
          end
        end
        FIX: begin
          busy_q <= 1'b0;
          if (kill_i) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            result_q <= result_d;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed scenarios plus randomized operations
// compared against an arithmetic reference model of the RV32M rules.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam int Lat = W + 1;
  localparam logic [W-1:0] MinInt = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         resetN;
  logic         start;
  logic         kill;
  logic [2:0]   mdop;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk_i      (clk),
    .reset_ni   (resetN),
    .start_i    (start),
    .mdop_i     (mdop),
    .operand1_i (op1),
    .operand2_i (op2),
    .kill_i     (kill),
    .busy_o     (busy),
    .done_o     (done),
    .result_o   (result)
  );

  // Reference model: RV32M results computed with plain 64-bit arithmetic.
  function automatic logic [W-1:0] refModel(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    logic [63:0] p;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return '1;
        if (a == MinInt && b == '1) return a;
        return 32'(sa / sb);
      end
      3'd5: begin
        if (b == 0) return '1;
        return 32'(ua / ub);
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == MinInt && b == '1) return '0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 0) return a;
        return 32'(ua % ub);
      end
    endcase
  endfunction

  task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1;
    mdop  = op;
    op1   = a;
    op2   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    mdop  = 3'($urandom);
    op1   = $urandom;
    op2   = $urandom;
  endtask

  task automatic waitDone(output int edges, output int busyCycles, output bit timedOut);
    edges = 0;
    busyCycles = 0;
    while (done !== 1'b1 && edges < 200) begin
      if (busy === 1'b1) busyCycles++;
      @(posedge clk);
      #1;
      edges++;
    end
    timedOut = (done !== 1'b1);
  endtask

  task automatic test_reset;
    resetN = 1'b0;
    start  = 1'b0;
    kill   = 1'b0;
    mdop   = '0;
    op1    = '0;
    op2    = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b want 0", done); end
    vectors++; if (result !== '0) begin miscompares++; $display("[TB] FAIL reset_result got %h want 0", result); end
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_mul_basic;
    int e, b;
    bit to;
    applyStimulus(3'd0, 32'd10, 32'd20);
    waitDone(e, b, to);
    vectors++; if (to) begin miscompares++; $display("[TB] FAIL mul_basic_timeout no DONE within 200 cycles"); end
    vectors++; if (result !== 32'd200) begin miscompares++; $display("[TB] FAIL mul_basic_result got %h want %h", result, 32'd200); end
    vectors++; if (e != Lat) begin miscompares++; $display("[TB] FAIL mul_basic_latency got %0d want %0d", e, Lat); end
    vectors++; if (b != Lat) begin miscompares++; $display("[TB] FAIL mul_basic_busy got %0d want %0d", b, Lat); end
    @(posedge clk);
    #1;
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL mul_done_pulse got %b want 0", done); end
    vectors++; if (result !== 32'd200) begin miscompares++; $display("[TB] FAIL mul_result_hold got %h want %h", result, 32'd200); end
  endtask

  task automatic test_mul_signs;
    logic [2:0]   ops  [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
    logic [W-1:0] exps [4] = '{32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0003, 32'hFFFF_FFFC};
    int e, b;
    bit to;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(ops[i], 32'd4, 32'hFFFF_FFFF);
      waitDone(e, b, to);
      vectors++;
      if (to || result !== exps[i]) begin
        miscompares++;
        $display("[TB] FAIL mul_signs op=%0d got %h want %h (timeout=%0b)", ops[i], result, exps[i], to);
      end
    end
  endtask

  task automatic test_div_directed;
    logic [2:0]   ops  [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [W-1:0] as   [4] = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd20, 32'd20};
    logic [W-1:0] bs   [4] = '{32'd3, 32'd3, 32'd10, 32'd3};
    logic [W-1:0] exps [4] = '{32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'd2, 32'd2};
    int e, b;
    bit to;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(ops[i], as[i], bs[i]);
      waitDone(e, b, to);
      vectors++;
      if (to || result !== exps[i]) begin
        miscompares++;
        $display("[TB] FAIL div_directed op=%0d got %h want %h (timeout=%0b)", ops[i], result, exps[i], to);
      end
      vectors++; if (e != Lat) begin miscompares++; $display("[TB] FAIL div_latency op=%0d got %0d want %0d", ops[i], e, Lat); end
    end
  endtask

  task automatic test_fast_path;
    logic [2:0]   ops  [4] = '{3'd5, 3'd7, 3'd4, 3'd6};
    logic [W-1:0] as   [4] = '{32'd20, 32'd20, MinInt, MinInt};
    logic [W-1:0] bs   [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [W-1:0] exps [4] = '{32'hFFFF_FFFF, 32'd20, MinInt, 32'd0};
    int e, b;
    bit to;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(ops[i], as[i], bs[i]);
      waitDone(e, b, to);
      vectors++;
      if (to || result !== exps[i]) begin
        miscompares++;
        $display("[TB] FAIL fast_result op=%0d got %h want %h (timeout=%0b)", ops[i], result, exps[i], to);
      end
      vectors++; if (e != 0) begin miscompares++; $display("[TB] FAIL fast_latency op=%0d got %0d want 0", ops[i], e); end
      vectors++; if (b != 0) begin miscompares++; $display("[TB] FAIL fast_busy op=%0d got %0d want 0", ops[i], b); end
    end
  endtask

  task automatic test_kill;
    int e, b;
    bit to;
    bit sawDone;
    applyStimulus(3'd0, 32'd6, 32'd7);
    waitDone(e, b, to);
    vectors++; if (to || result !== 32'd42) begin miscompares++; $display("[TB] FAIL kill_prior got %h want %h", result, 32'd42); end
    applyStimulus(3'd0, 32'd7, 32'd9);
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL kill_busy got %b want 0", busy); end
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) sawDone = 1'b1;
      @(posedge clk);
      #1;
    end
    vectors++; if (sawDone) begin miscompares++; $display("[TB] FAIL kill_no_done got 1 want 0"); end
    vectors++; if (result !== 32'd42) begin miscompares++; $display("[TB] FAIL kill_result_hold got %h want %h", result, 32'd42); end
    applyStimulus(3'd0, 32'd3, 32'd5);
    waitDone(e, b, to);
    vectors++; if (to || result !== 32'd15) begin miscompares++; $display("[TB] FAIL after_kill_result got %h want %h", result, 32'd15); end
    vectors++; if (e != Lat) begin miscompares++; $display("[TB] FAIL after_kill_latency got %0d want %0d", e, Lat); end
    kill = 1'b1;
    applyStimulus(3'd0, 32'd11, 32'd13);
    kill = 1'b0;
    waitDone(e, b, to);
    vectors++; if (to || result !== 32'd143) begin miscompares++; $display("[TB] FAIL kill_start_idle got %h want %h", result, 32'd143); end
  endtask

  task automatic test_reset_mid;
    applyStimulus(3'd4, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    resetN = 1'b0;
    @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_done got %b want 0", done); end
    vectors++; if (result !== '0) begin miscompares++; $display("[TB] FAIL midreset_result got %h want 0", result); end
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_back_to_back;
    int e, b;
    bit to;
    applyStimulus(3'd0, 32'd2, 32'd3);
    waitDone(e, b, to);
    vectors++; if (to || result !== 32'd6) begin miscompares++; $display("[TB] FAIL b2b_first got %h want %h", result, 32'd6); end
    start = 1'b1;
    mdop  = 3'd0;
    op1   = 32'd4;
    op2   = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    op1   = $urandom;
    op2   = $urandom;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_busy got %b want 1", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_done got %b want 0", done); end
    waitDone(e, b, to);
    vectors++; if (to || result !== 32'd20) begin miscompares++; $display("[TB] FAIL b2b_second got %h want %h", result, 32'd20); end
    vectors++; if (e != Lat) begin miscompares++; $display("[TB] FAIL b2b_latency got %0d want %0d", e, Lat); end
  endtask

  task automatic test_start_ignored;
    int e, b;
    bit to;
    applyStimulus(3'd0, 32'd3, 32'd3);
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    mdop  = 3'd5;
    op1   = 32'd1000;
    op2   = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(e, b, to);
    vectors++; if (to || result !== 32'd9) begin miscompares++; $display("[TB] FAIL busy_start_result got %h want %h", result, 32'd9); end
    vectors++; if (e + 6 != Lat) begin miscompares++; $display("[TB] FAIL busy_start_latency got %0d want %0d", e + 6, Lat); end
  endtask

  task automatic test_random;
    int e, b;
    bit to;
    logic [2:0]   op;
    logic [W-1:0] a, d, expRes;
    bit fast;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       begin a = $urandom; d = '0; end
        1:       begin a = MinInt; d = '1; end
        2:       begin a = 32'($urandom_range(0, 300)); d = 32'($urandom_range(1, 17)); end
        3:       begin a = -32'($urandom_range(1, 300)); d = 32'($urandom_range(1, 17)); end
        default: begin a = $urandom; d = $urandom; end
      endcase
      expRes = refModel(op, a, d);
      fast = op[2] && (d == '0 || (!op[0] && a == MinInt && d == '1));
      applyStimulus(op, a, d);
      waitDone(e, b, to);
      vectors++;
      if (to || result !== expRes) begin
        miscompares++;
        $display("[TB] FAIL random_result op=%0d a=%h b=%h got %h want %h", op, a, d, result, expRes);
      end
      vectors++;
      if (e != (fast ? 0 : Lat)) begin
        miscompares++;
        $display("[TB] FAIL random_latency op=%0d got %0d want %0d", op, e, fast ? 0 : Lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_mul_signs();
    test_div_directed();
    test_fast_path();
    test_kill();
    test_reset_mid();
    test_back_to_back();
    test_start_ignored();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
